// File: rtl/extend_pkg.sv
// Shared types for the immediate-extension pipeline: format selector codes and buffered item layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package extend_pkg;

    localparam int NBW_IMMSRC  = 3;
    // Item fields are sized for the widest legal configuration; users fill the low bits.
    localparam int NBW_IMM_MAX = 64;
    localparam int NBW_TAG_MAX = 16;

    typedef enum logic [NBW_IMMSRC-1:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_RSV6 = 3'b110,
        IMM_RSV7 = 3'b111
    } imm_src_t;

    typedef struct packed {
        logic [NBW_IMM_MAX-1:0] imm;
        logic [NBW_TAG_MAX-1:0] tag;
        logic                   illegal;
    } imm_item_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction and extension to register width.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no flow control at this level.
module imm_decode
    import extend_pkg::*;
#(
    parameter int NBW_INST     = 32,
    parameter int NBW_REGISTER = 32
) (
    input  logic [NBW_INST-1:0]     inst,
    input  logic [NBW_IMMSRC-1:0]   immSrc,
    output logic [NBW_REGISTER-1:0] immExt,
    output logic                    illegal
);

    logic [31:0] imm32;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Build the 32-bit immediate per format; reserved codes yield zero and flag illegal.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src_t'(immSrc))
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            // zimm has bit 31 clear, so the common sign extension below zero-extends it.
            IMM_Z:   imm32 = {27'b0, inst[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign immExt = NBW_REGISTER'(signed'(imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a two-entry skid buffer (output register + skid register).
// Latency: 1 cycle from accept to o_valid when the output register is free or draining.
// Backpressure: o_ready = !skid valid (registered); a stalled output diverts one item to skid.
module imm_extend_pipe
    import extend_pkg::*;
#(
    parameter int NBW_INST     = 32,
    parameter int NBW_REGISTER = 32,   // 32 or 64
    parameter int NBW_TAG      = 4     // at most NBW_TAG_MAX
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [NBW_INST-1:0]     i_inst,
    input  logic [2:0]              i_immSrc,
    input  logic [NBW_TAG-1:0]      i_tag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NBW_REGISTER-1:0] o_immExt,
    output logic [NBW_TAG-1:0]      o_tag,
    output logic                    o_illegal
);

    logic [NBW_REGISTER-1:0] dec_imm;
    logic                    dec_illegal;
    imm_item_t               in_item;
    imm_item_t               out_q, out_d, skid_q, skid_d;
    logic                    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic                    in_fire, out_free;

    imm_decode #(
        .NBW_INST     (NBW_INST),
        .NBW_REGISTER (NBW_REGISTER)
    ) u_decode (
        .inst    (i_inst),
        .immSrc  (i_immSrc),
        .immExt  (dec_imm),
        .illegal (dec_illegal)
    );

    // Pack the decoded item into the widest-case layout.
    always_comb begin
        in_item                     = '0;
        in_item.imm[NBW_REGISTER-1:0] = dec_imm;
        in_item.tag[NBW_TAG-1:0]      = i_tag;
        in_item.illegal             = dec_illegal;
    end

    assign in_fire  = i_valid && !skid_vld_q;
    assign out_free = !out_vld_q || i_ready;

    // Skid control: skid drains first, otherwise new items go to output or, when stalled, to skid.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            // o_ready is low, so nothing can be accepted this cycle.
            if (out_free) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            if (out_free) begin
                out_d     = in_item;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = in_item;
                skid_vld_d = 1'b1;
            end
        end else if (out_vld_q && i_ready) begin
            out_vld_d = 1'b0;
        end
        // Flush drops everything, including an item presented this cycle.
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    // State registers; reset overrides flush and clears visible data too.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_valid   = out_vld_q;
    assign o_ready   = !skid_vld_q;
    assign o_immExt  = out_q.imm[NBW_REGISTER-1:0];
    assign o_tag     = out_q.tag[NBW_TAG-1:0];
    assign o_illegal = out_q.illegal;

    // Upper field bits beyond the configured widths are always zero.
    logic unused_hi;
    assign unused_hi = ^{out_q.imm >> NBW_REGISTER, out_q.tag >> NBW_TAG};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe at 32- and 64-bit register widths.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised through i_ready stalls, flush and reset.
module tb_imm_extend_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_flush, i_valid, i_ready;
    logic [31:0] i_inst;
    logic [2:0]  i_immSrc;
    logic [3:0]  i_tag;

    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_immExt;
    logic [3:0]  o_tag;
    logic        o_ready64, o_valid64, o_illegal64;
    logic [63:0] o_immExt64;
    logic [3:0]  o_tag64;

    int checks   = 0;
    int failures = 0;

    // {valid, ready, illegal, tag, imm}
    logic [38:0] obs;
    logic [70:0] obs64;
    assign obs   = {o_valid, o_ready, o_illegal, o_tag, o_immExt};
    assign obs64 = {o_valid64, o_ready64, o_illegal64, o_tag64, o_immExt64};

    always #5 i_clk = ~i_clk;

    imm_extend_pipe #(.NBW_INST(32), .NBW_REGISTER(32), .NBW_TAG(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
        .i_immSrc(i_immSrc), .i_tag(i_tag), .o_valid(o_valid),
        .i_ready(i_ready), .o_immExt(o_immExt), .o_tag(o_tag),
        .o_illegal(o_illegal)
    );

    imm_extend_pipe #(.NBW_INST(32), .NBW_REGISTER(64), .NBW_TAG(4)) dut64 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready64), .i_inst(i_inst),
        .i_immSrc(i_immSrc), .i_tag(i_tag), .o_valid(o_valid64),
        .i_ready(i_ready), .o_immExt(o_immExt64), .o_tag(o_tag64),
        .o_illegal(o_illegal64)
    );

    task automatic test_reset();
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_inst = '0; i_immSrc = '0; i_tag = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h0}) begin
            failures++; $display("FAIL reset32: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 4'h0, 32'h0});
        end
        checks++;
        if (obs64 !== {1'b0, 1'b1, 1'b0, 4'h0, 64'h0}) begin
            failures++; $display("FAIL reset64: got %h expected %h", obs64, {1'b0, 1'b1, 1'b0, 4'h0, 64'h0});
        end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++; $display("FAIL reset_idle: got %b expected 01", {o_valid, o_ready});
        end
    endtask

    task automatic test_i_format();
        i_ready = 1'b1; i_valid = 1'b1; i_inst = 32'hFFF00093; i_immSrc = 3'b000; i_tag = 4'h5;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 4'h5, 32'hFFFFFFFF}) begin
            failures++; $display("FAIL i_format: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 4'h5, 32'hFFFFFFFF});
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL i_format_drain: got %b expected 0", o_valid);
        end
    endtask

    // B, J and S items back-to-back with one output per cycle.
    task automatic test_back_to_back();
        logic [31:0] inst_t [0:2];
        logic [2:0]  src_t  [0:2];
        logic [31:0] exp_t  [0:2];
        inst_t = '{32'hFE000EE3, 32'h0080006F, 32'hFE112E23};
        src_t  = '{3'b010, 3'b100, 3'b001};
        exp_t  = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC};
        i_ready = 1'b1; i_valid = 1'b1;
        i_inst = inst_t[0]; i_immSrc = src_t[0]; i_tag = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, 4'(i + 1), exp_t[i]}) begin
                failures++; $display("FAIL b2b_%0d: got %h expected %h", i, obs, {1'b1, 1'b1, 1'b0, 4'(i + 1), exp_t[i]});
            end
            if (i < 2) begin
                i_inst = inst_t[i+1]; i_immSrc = src_t[i+1]; i_tag = 4'(i + 2);
            end else begin
                i_valid = 1'b0;
            end
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_end: got %b expected 0", o_valid);
        end
    endtask

    // U, zimm and reserved formats at both register widths.
    task automatic test_wide_formats();
        logic [31:0] inst_t [0:3];
        logic [2:0]  src_t  [0:3];
        logic [63:0] exp64  [0:3];
        logic [31:0] exp32  [0:3];
        logic        ill_t  [0:3];
        inst_t = '{32'h800000B7, 32'h800F8073, 32'hFFFFFFFF, 32'hFFFFFFFF};
        src_t  = '{3'b011, 3'b101, 3'b111, 3'b110};
        exp64  = '{64'hFFFFFFFF80000000, 64'h1F, 64'h0, 64'h0};
        exp32  = '{32'h80000000, 32'h1F, 32'h0, 32'h0};
        ill_t  = '{1'b0, 1'b0, 1'b1, 1'b1};
        i_ready = 1'b1; i_valid = 1'b1;
        i_inst = inst_t[0]; i_immSrc = src_t[0]; i_tag = 4'd8;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (obs64 !== {1'b1, 1'b1, ill_t[i], 4'(i + 8), exp64[i]}) begin
                failures++; $display("FAIL wide64_%0d: got %h expected %h", i, obs64, {1'b1, 1'b1, ill_t[i], 4'(i + 8), exp64[i]});
            end
            checks++;
            if (obs !== {1'b1, 1'b1, ill_t[i], 4'(i + 8), exp32[i]}) begin
                failures++; $display("FAIL wide32_%0d: got %h expected %h", i, obs, {1'b1, 1'b1, ill_t[i], 4'(i + 8), exp32[i]});
            end
            if (i < 3) begin
                i_inst = inst_t[i+1]; i_immSrc = src_t[i+1]; i_tag = 4'(i + 9);
            end else begin
                i_valid = 1'b0;
            end
        end
        @(posedge i_clk); #1;
    endtask

    // Tags 1,2,3 under a stall: tag 1 held, tag 2 skidded, tag 3 waits for o_ready.
    task automatic test_backpressure();
        logic [38:0] exp_t [0:5];
        exp_t = '{{1'b1, 1'b1, 1'b0, 4'd1, 32'd1},
                  {1'b1, 1'b0, 1'b0, 4'd1, 32'd1},
                  {1'b1, 1'b0, 1'b0, 4'd1, 32'd1},
                  {1'b1, 1'b1, 1'b0, 4'd2, 32'd2},
                  {1'b1, 1'b1, 1'b0, 4'd3, 32'd3},
                  {1'b0, 1'b1, 1'b0, 4'd3, 32'd3}};
        i_ready = 1'b0; i_valid = 1'b1; i_immSrc = 3'b000;
        i_tag = 4'd1; i_inst = 32'd1 << 20;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (obs !== exp_t[i]) begin
                failures++; $display("FAIL bp_%0d: got %h expected %h", i, obs, exp_t[i]);
            end
            case (i)
                0: begin i_tag = 4'd2; i_inst = 32'd2 << 20; end
                1: begin i_tag = 4'd3; i_inst = 32'd3 << 20; end
                2: i_ready = 1'b1;
                4: i_valid = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_flush();
        i_ready = 1'b0; i_valid = 1'b1; i_immSrc = 3'b000;
        i_tag = 4'd7; i_inst = 32'd7 << 20;
        @(posedge i_clk); #1;
        i_tag = 4'd8; i_inst = 32'd8 << 20;
        @(posedge i_clk); #1;
        checks++;
        if ({o_valid, o_ready, o_tag} !== {1'b1, 1'b0, 4'd7}) begin
            failures++; $display("FAIL flush_fill: got %h expected %h", {o_valid, o_ready, o_tag}, {1'b1, 1'b0, 4'd7});
        end
        i_flush = 1'b1; i_tag = 4'd9; i_inst = 32'd9 << 20;
        @(posedge i_clk); #1;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_clear: got %b expected 01", {o_valid, o_ready});
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_drop: got %b expected 01", {o_valid, o_ready});
        end
        i_flush = 1'b0; i_tag = 4'hB; i_inst = 32'hB << 20;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 4'hB, 32'hB}) begin
            failures++; $display("FAIL flush_resume: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 4'hB, 32'hB});
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_over_flush();
        i_ready = 1'b0; i_valid = 1'b1;
        i_immSrc = 3'b111; i_inst = 32'hFFFFFFFF; i_tag = 4'hA;
        @(posedge i_clk); #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b1, 4'hA, 32'h0}) begin
            failures++; $display("FAIL rst_fill: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 4'hA, 32'h0});
        end
        i_immSrc = 3'b000; i_inst = 32'h00500093; i_tag = 4'h5;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0; i_flush = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h0}) begin
            failures++; $display("FAIL rst_over_flush: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 4'h0, 32'h0});
        end
        i_rst_n = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            failures++; $display("FAIL rst_no_output: got %b expected 01", {o_valid, o_ready});
        end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_wide_formats();
        test_backpressure();
        test_flush();
        test_reset_over_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
